// File: rtl/kypd_column_scanner_if.sv
// Key handshake between the KYPD column scanner (master) and its consumer (slave).
// A key code transfers on any cycle where key_valid and key_ready are both high.
interface kypd_column_scanner_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (
    output key_valid,
    output key_code,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output key_ready
  );
endinterface

// File: rtl/kypd_column_scanner.sv
// Digilent KYPD 4x4 column scanner: drives one column low at a time, samples the rows,
// reports each press once as a hex legend code, and holds the column until release.
module kypd_column_scanner #(
  parameter real ClockFrequencyInMHz  = 100.0,
  parameter real SettleTimeInMicroSec = 1.0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [3:0]                   row_i,
  output logic [3:0]                   col_o,
  kypd_column_scanner_if.master        key_if
);

  localparam int unsigned SettleCntMod = $rtoi(ClockFrequencyInMHz * SettleTimeInMicroSec + 0.5);
  localparam int unsigned CntW         = $clog2(SettleCntMod + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(SettleCntMod - 1);

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    REPORT,
    WAIT_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      col_q, col_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;

  logic            cnt_last;
  logic            rows_idle;
  logic [1:0]      row_sel;

  // Printed legend of the KYPD, indexed by {row, column}.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  assign cnt_last  = (cnt_q == CntLast);
  assign rows_idle = (row_i == 4'hF);

  // Lowest-indexed active (low) row wins when several keys share the column.
  always_comb begin
    row_sel = 2'd3;
    if      (!row_i[0]) row_sel = 2'd0;
    else if (!row_i[1]) row_sel = 2'd1;
    else if (!row_i[2]) row_sel = 2'd2;
  end

  // NOTE: every *_d gets a default of its *_q first, so no path through the case
  // leaves a combinational output unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    col_d       = col_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;

    case (state_q)
      DRIVE: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      SAMPLE: begin
        if (rows_idle) begin
          col_idx_d = col_idx_q + 2'd1;
          col_d     = {col_q[2:0], col_q[3]};
          state_d   = DRIVE;
        end else begin
          key_code_d  = key_map(row_sel, col_idx_q);
          key_valid_d = 1'b1;
          state_d     = REPORT;
        end
      end

      REPORT: begin
        if (key_if.key_ready) begin
          key_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = WAIT_RELEASE;
        end
      end

      WAIT_RELEASE: begin
        // Any bounce back to a pressed row restarts the release window.
        if (!rows_idle) begin
          cnt_d = '0;
        end else if (cnt_last) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          col_d     = {col_q[2:0], col_q[3]};
          state_d   = DRIVE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = DRIVE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= DRIVE;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign col_o            = col_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.key_code  = key_code_q;

endmodule

// File: tb/tb_kypd_column_scanner.sv
// Cycle-by-cycle directed vectors for the KYPD column scanner with SettleCntMod = 4
// (5-cycle dwell per idle column).
module tb_kypd_column_scanner;

  typedef struct {
    string      tag;
    logic       rst;
    logic [3:0] row;
    logic       rdy;
    logic [3:0] exp_col;
    logic       exp_valid;
    logic [3:0] exp_code;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] row_i;
  logic [3:0] col_o;

  kypd_column_scanner_if key_if ();

  kypd_column_scanner #(
    .ClockFrequencyInMHz  (1.0),
    .SettleTimeInMicroSec (4.0)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .row_i   (row_i),
    .col_o   (col_o),
    .key_if  (key_if)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic void add(input string tag, input logic rst, input logic [3:0] row,
                              input logic rdy, input logic [3:0] col, input logic v,
                              input logic [3:0] code);
    vec_t x;
    x.tag = tag; x.rst = rst; x.row = row; x.rdy = rdy;
    x.exp_col = col; x.exp_valid = v; x.exp_code = code;
    vecs.push_back(x);
  endfunction

  // Idle scan column k cycles after a reset edge: 5 cycles per column.
  function automatic logic [3:0] idle_col(input int k);
    logic [3:0] one;
    int         idx;
    one = 4'b0001;
    idx = (k / 5) % 4;
    return ~(one << idx);
  endfunction

  initial begin
    // 1: idle rotation, no reports for 100 cycles
    add("s1_rst", 1, 4'hF, 0, 4'b1110, 0, 4'h0);
    for (int k = 1; k <= 100; k++) add("s1_idle", 0, 4'hF, 0, idle_col(k), 0, 4'h0);

    // 2: key 5 (row1, col1), ready held high, release after 4 F cycles
    add("s2_rst", 1, 4'hF, 1, 4'b1110, 0, 4'h0);
    for (int k = 1; k <= 5; k++)   add("s2_scan", 0, 4'hF, 1, idle_col(k), 0, 4'h0);
    for (int k = 6; k <= 9; k++)   add("s2_drive", 0, 4'hD, 1, 4'b1101, 0, 4'h0);
    add("s2_valid", 0, 4'hD, 1, 4'b1101, 1, 4'h5);
    for (int k = 11; k <= 13; k++) add("s2_held", 0, 4'hD, 1, 4'b1101, 0, 4'h5);
    for (int k = 14; k <= 16; k++) add("s2_rel", 0, 4'hF, 1, 4'b1101, 0, 4'h5);
    for (int k = 17; k <= 21; k++) add("s2_next", 0, 4'hF, 1, 4'b1011, 0, 4'h5);
    add("s2_wrap", 0, 4'hF, 1, 4'b0111, 0, 4'h5);

    // 3: key D (row3, col3), consumer stalls 10 cycles, row change during REPORT ignored
    add("s3_rst", 1, 4'hF, 0, 4'b1110, 0, 4'h0);
    for (int k = 1; k <= 15; k++)  add("s3_scan", 0, 4'hF, 0, idle_col(k), 0, 4'h0);
    for (int k = 16; k <= 19; k++) add("s3_drive", 0, 4'h7, 0, 4'b0111, 0, 4'h0);
    add("s3_valid", 0, 4'h7, 0, 4'b0111, 1, 4'hD);
    for (int k = 21; k <= 24; k++) add("s3_stall", 0, 4'h7, 0, 4'b0111, 1, 4'hD);
    for (int k = 25; k <= 30; k++) add("s3_stall_rowchg", 0, 4'hF, 0, 4'b0111, 1, 4'hD);
    add("s3_accept", 0, 4'hF, 1, 4'b0111, 0, 4'hD);
    for (int k = 32; k <= 34; k++) add("s3_rel", 0, 4'hF, 1, 4'b0111, 0, 4'hD);
    add("s3_wrap", 0, 4'hF, 1, 4'b1110, 0, 4'hD);

    // 4: rows 0 and 2 low at col2 -> lowest row wins, key 3, one pulse
    add("s4_rst", 1, 4'hF, 1, 4'b1110, 0, 4'h0);
    for (int k = 1; k <= 10; k++)  add("s4_scan", 0, 4'hF, 1, idle_col(k), 0, 4'h0);
    for (int k = 11; k <= 14; k++) add("s4_drive", 0, 4'hA, 1, 4'b1011, 0, 4'h0);
    add("s4_valid", 0, 4'hA, 1, 4'b1011, 1, 4'h3);
    for (int k = 16; k <= 17; k++) add("s4_held", 0, 4'hA, 1, 4'b1011, 0, 4'h3);
    for (int k = 18; k <= 20; k++) add("s4_rel", 0, 4'hF, 1, 4'b1011, 0, 4'h3);
    add("s4_next", 0, 4'hF, 1, 4'b0111, 0, 4'h3);

    // 5: key 1, release window restarted by a bounce: F,F,E,F,F,F,F
    add("s5_rst", 1, 4'hF, 1, 4'b1110, 0, 4'h0);
    for (int k = 1; k <= 4; k++) add("s5_drive", 0, 4'hE, 1, 4'b1110, 0, 4'h0);
    add("s5_valid", 0, 4'hE, 1, 4'b1110, 1, 4'h1);
    add("s5_accept", 0, 4'hE, 1, 4'b1110, 0, 4'h1);
    add("s5_f1", 0, 4'hF, 1, 4'b1110, 0, 4'h1);
    add("s5_f2", 0, 4'hF, 1, 4'b1110, 0, 4'h1);
    add("s5_bounce", 0, 4'hE, 1, 4'b1110, 0, 4'h1);
    for (int k = 10; k <= 12; k++) add("s5_rel", 0, 4'hF, 1, 4'b1110, 0, 4'h1);
    for (int k = 13; k <= 17; k++) add("s5_next", 0, 4'hF, 1, 4'b1101, 0, 4'h1);
    add("s5_next2", 0, 4'hF, 1, 4'b1011, 0, 4'h1);

    // 6: reset while key 0 is pending in REPORT, then normal 5-cycle dwell
    add("s6_rst", 1, 4'hF, 0, 4'b1110, 0, 4'h0);
    for (int k = 1; k <= 4; k++) add("s6_drive", 0, 4'h7, 0, 4'b1110, 0, 4'h0);
    add("s6_valid", 0, 4'h7, 0, 4'b1110, 1, 4'h0);
    add("s6_stall", 0, 4'h7, 0, 4'b1110, 1, 4'h0);
    add("s6_midrst", 1, 4'h7, 1, 4'b1110, 0, 4'h0);
    for (int k = 1; k <= 10; k++) add("s6_resume", 0, 4'hF, 0, idle_col(k), 0, 4'h0);

    reset_i          = 1'b1;
    row_i            = 4'hF;
    key_if.key_ready = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      reset_i          = vecs[i].rst;
      row_i            = vecs[i].row;
      key_if.key_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      nm = $sformatf("%s[%0d]", vecs[i].tag, i);
      check({nm, ".col"}, col_o, vecs[i].exp_col);
      check({nm, ".valid"}, {3'b000, key_if.key_valid}, {3'b000, vecs[i].exp_valid});
      check({nm, ".code"}, key_if.key_code, vecs[i].exp_code);
      check({nm, ".onelow"}, 4'($countones(col_o)), 4'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
